// File: rtl/demux_rr_dispatcher_if.sv
// Handshake bundle for the 1-to-4 demux dispatcher.
//   i, i_valid, i_ready : single producer-side word stream
//   o0..o3, v0..v3      : per-channel data and valid toward the consumers
//   r0..r3              : per-channel ready from the consumers
// slave  : the dispatcher's view (drives i_ready, o*, v*)
// master : the producer/consumer environment's view
interface demux_rr_dispatcher_if #(
    parameter int width = 4
);
    logic [width-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic [width-1:0] o0, o1, o2, o3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;

    modport slave (
        input  i, i_valid, r0, r1, r2, r3,
        output i_ready, o0, o1, o2, o3, v0, v1, v2, v3
    );

    modport master (
        output i, i_valid, r0, r1, r2, r3,
        input  i_ready, o0, o1, o2, o3, v0, v1, v2, v3
    );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Flow-controlled 1-to-4 demux scheduler. Each output channel owns a
// one-entry holding register; words go round-robin in bursts of BURST beats,
// or to dst_sel when mode=1. mode/dst_sel are only looked at when a burst
// starts (cnt==0).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : input stream i/i_valid/i_ready, channels o*/v*/r*
//   mode         : 0 = round-robin, 1 = fixed target from dst_sel
//   dst_sel      : fixed-mode target channel
//   busy         : any channel holding a word, or a burst in progress
// Scheduler state:
//   ptr        | current / next round-robin target
//   cnt        | beats sent in the current burst (0..BURST-1)
//   burst_mode | mode captured at the first beat of the burst
module demux_rr_dispatcher #(
    parameter int width = 4,
    parameter int BURST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_rr_dispatcher_if.slave  bus,
    input  logic                  mode,
    input  logic [1:0]            dst_sel,
    output logic                  busy
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    logic [1:0]       ptr, ptr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             burst_mode, burst_mode_nxt;
    logic [3:0]       v_q, v_nxt;
    logic [width-1:0] o_q   [4];
    logic [width-1:0] o_nxt [4];

    logic [3:0] r_vec;
    logic [3:0] avail;
    logic [1:0] tgt;
    logic       cur_mode;
    logic       last_beat;
    logic       accept;

    assign r_vec     = {bus.r3, bus.r2, bus.r1, bus.r0};
    // A slot can take a word if empty or being drained this very cycle.
    assign avail     = ~v_q | r_vec;
    assign tgt       = (cnt == '0 && mode) ? dst_sel : ptr;
    // Mid-burst the burst's own mode governs how ptr moves at its end.
    assign cur_mode  = (cnt == '0) ? mode : burst_mode;
    assign last_beat = (cnt == CW'(BURST - 1));
    assign accept    = bus.i_valid && bus.i_ready;

    assign bus.i_ready = !rst && avail[tgt];

    always_comb begin
        ptr_nxt        = ptr;
        cnt_nxt        = cnt;
        burst_mode_nxt = burst_mode;
        v_nxt          = v_q;
        o_nxt          = o_q;

        for (int k = 0; k < 4; k++) begin
            if (v_q[k] && r_vec[k]) begin
                v_nxt[k] = 1'b0;
                o_nxt[k] = '0;
            end
        end

        if (accept) begin
            // Overrides a same-cycle drain of the target channel.
            o_nxt[tgt] = bus.i;
            v_nxt[tgt] = 1'b1;
            if (cnt == '0) begin
                burst_mode_nxt = mode;
            end
            if (last_beat) begin
                cnt_nxt = '0;
                ptr_nxt = cur_mode ? tgt : tgt + 2'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
                ptr_nxt = tgt;
            end
        end else if (cnt == '0 && !mode && !avail[ptr]) begin
            // Step past a blocked channel; a started burst is never abandoned.
            ptr_nxt = ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            burst_mode <= 1'b0;
            v_q        <= '0;
            o_q        <= '{default: '0};
        end else begin
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            burst_mode <= burst_mode_nxt;
            v_q        <= v_nxt;
            o_q        <= o_nxt;
        end
    end

    assign bus.o0 = o_q[0];
    assign bus.o1 = o_q[1];
    assign bus.o2 = o_q[2];
    assign bus.o3 = o_q[3];
    assign bus.v0 = v_q[0];
    assign bus.v1 = v_q[1];
    assign bus.v2 = v_q[2];
    assign bus.v3 = v_q[3];

    assign busy = (|v_q) || (cnt != '0);
endmodule
